// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the CPU / I/O-DMA memory port arbiter:
// FSM state encodings, grant codes and the wait-state counter width.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_CPU  = 2'b01,
    GRANT_IO   = 2'b10
  } grant_t;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between a CPU and an I/O-DMA
// requester; each access strobes memory for WAIT_STATES cycles, then acks.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        io_req,
  input  logic        io_we,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_wdata,
  output logic        io_ack,
  output logic [15:0] io_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        busy
);

  state_t            state, state_next;
  grant_t            grant_q;
  logic              last_io;
  logic              we_q;
  logic [15:0]       addr_q, wdata_q;
  logic [15:0]       cpu_rdata_q, io_rdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              take, pick_io;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    pick_io    = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    cpu_ack    = 1'b0;
    io_ack     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (cpu_req || io_req) begin
          take       = 1'b1;
          // On a tie the side not served last wins; last_io starts at IO.
          pick_io    = io_req && (!cpu_req || !last_io);
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_re = !we_q;
        mem_we = we_q;
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        cpu_ack    = (grant_q == GRANT_CPU);
        io_ack     = (grant_q == GRANT_IO);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      grant_q     <= GRANT_NONE;
      last_io     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            grant_q <= pick_io ? GRANT_IO : GRANT_CPU;
            addr_q  <= pick_io ? io_addr  : cpu_addr;
            wdata_q <= pick_io ? io_wdata : cpu_wdata;
            we_q    <= pick_io ? io_we    : cpu_we;
            cnt     <= CNT_W'(WAIT_STATES - 1);
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) begin
              if (grant_q == GRANT_IO) io_rdata_q  <= mem_rdata;
              else                     cpu_rdata_q <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          last_io <= (grant_q == GRANT_IO);
          grant_q <= GRANT_NONE;
        end
        default: ;
      endcase
    end
  end

  assign grant     = grant_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign io_rdata  = io_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (WAIT_STATES 1 and 3), a table of
// request vectors, per-instance monitors popping an expected-transaction queue.
module tb_mem_port_arbiter;

  typedef struct {
    logic        is_io;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  typedef struct {
    int          inst;
    logic        cpu_en;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        io_en;
    logic        io_we;
    logic [15:0] io_addr;
    logic [15:0] io_wdata;
    logic        first_io;
  } vec_t;

  logic        CLK = 1'b0;
  logic        rst [2];
  logic        cpu_req [2], cpu_we [2], io_req [2], io_we [2];
  logic [15:0] cpu_addr [2], cpu_wdata [2], io_addr [2], io_wdata [2];
  logic [15:0] mem_rdata [2];
  logic        cpu_ack [2], io_ack [2], mem_re [2], mem_we [2], busy [2];
  logic [15:0] cpu_rdata [2], io_rdata [2], mem_addr [2], mem_wdata [2];
  logic [1:0]  grant [2];
  logic [15:0] mrd_cpu [2], mrd_io [2];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  function automatic void chk(string name, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] rd_model(logic [15:0] a);
    if (a == 16'h0040) return 16'hBEEF;
    return (a ^ 16'hC3A5) + 16'd7;
  endfunction

  function automatic logic [79:0] outs(int k);
    return 80'({grant[k], busy[k], mem_re[k], mem_we[k], cpu_ack[k], io_ack[k],
                mem_addr[k], mem_wdata[k], cpu_rdata[k], io_rdata[k]});
  endfunction

  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int unsigned WS = (g == 0) ? 1 : 3;
    txn_t q[$];
    int   run = 0;
    logic prev_strobe = 1'b0;

    mem_port_arbiter #(.WAIT_STATES(WS)) dut (
      .CLK(CLK), .Reset(rst[g]),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_ack(cpu_ack[g]), .cpu_rdata(cpu_rdata[g]),
      .io_req(io_req[g]), .io_we(io_we[g]), .io_addr(io_addr[g]),
      .io_wdata(io_wdata[g]), .io_ack(io_ack[g]), .io_rdata(io_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_re(mem_re[g]),
      .mem_we(mem_we[g]), .mem_rdata(mem_rdata[g]), .grant(grant[g]), .busy(busy[g])
    );

    // Read data is only valid during the final strobe cycle.
    assign mem_rdata[g] = (mem_re[g] && run == int'(WS)) ? rd_model(mem_addr[g]) : 16'hDEAD;

    always @(negedge CLK) begin
      if (rst[g]) begin
        run = 0;
        prev_strobe = 1'b0;
      end else begin
        chk("strobe_exclusive", 80'(mem_re[g] & mem_we[g]), 80'(0));
        chk("grant_legal", 80'(grant[g] == 2'b11), 80'(0));
        if (mem_re[g] || mem_we[g]) begin
          if (q.size() == 0) begin
            chk("unexpected_strobe", 80'({mem_re[g], mem_we[g]}), 80'(0));
          end else begin
            chk("strobe_addr", 80'(mem_addr[g]), 80'(q[0].addr));
            chk("strobe_dir", 80'({mem_re[g], mem_we[g]}), 80'(q[0].we ? 2'b01 : 2'b10));
            if (q[0].we) chk("strobe_wdata", 80'(mem_wdata[g]), 80'(q[0].wdata));
            chk("strobe_grant", 80'(grant[g]), 80'(q[0].is_io ? 2'b10 : 2'b01));
            run++;
          end
        end
        if (cpu_ack[g] || io_ack[g]) begin
          if (q.size() == 0) begin
            chk("unexpected_ack", 80'({cpu_ack[g], io_ack[g]}), 80'(0));
          end else begin
            chk("ack_owner", 80'({cpu_ack[g], io_ack[g]}), 80'(q[0].is_io ? 2'b01 : 2'b10));
            chk("ack_latency", 80'({prev_strobe, 32'(run)}), 80'({1'b1, 32'(WS)}));
            chk("ack_rdata", 80'(q[0].is_io ? io_rdata[g] : cpu_rdata[g]), 80'(q[0].rdata));
            void'(q.pop_front());
            run = 0;
          end
        end
        prev_strobe = mem_re[g] | mem_we[g];
      end
    end
  end

  task automatic push_txn(int k, txn_t t);
    if (k == 0) mon[0].q.push_back(t);
    else        mon[1].q.push_back(t);
  endtask

  task automatic run_vec(input vec_t v);
    int   k = v.inst;
    bit   cd, id;
    txn_t tc, ti;
    tc = '{1'b0, v.cpu_we, v.cpu_addr, v.cpu_wdata,
           v.cpu_we ? mrd_cpu[k] : rd_model(v.cpu_addr)};
    ti = '{1'b1, v.io_we, v.io_addr, v.io_wdata,
           v.io_we ? mrd_io[k] : rd_model(v.io_addr)};
    if (v.cpu_en && v.io_en && v.first_io) begin
      push_txn(k, ti);
      push_txn(k, tc);
    end else begin
      if (v.cpu_en) push_txn(k, tc);
      if (v.io_en)  push_txn(k, ti);
    end
    if (v.cpu_en) mrd_cpu[k] = tc.rdata;
    if (v.io_en)  mrd_io[k]  = ti.rdata;
    @(posedge CLK); #1;
    cpu_req[k] = v.cpu_en; cpu_we[k] = v.cpu_we; cpu_addr[k] = v.cpu_addr; cpu_wdata[k] = v.cpu_wdata;
    io_req[k]  = v.io_en;  io_we[k]  = v.io_we;  io_addr[k]  = v.io_addr;  io_wdata[k]  = v.io_wdata;
    cd = !v.cpu_en;
    id = !v.io_en;
    for (int c = 0; c < 60 && !(cd && id); c++) begin
      @(posedge CLK); #1;
      if (cpu_ack[k]) begin cpu_req[k] = 1'b0; cd = 1'b1; end
      if (io_ack[k])  begin io_req[k]  = 1'b0; id = 1'b1; end
    end
    chk("vec_completed", 80'({cd, id}), 80'(2'b11));
    cpu_req[k] = 1'b0;
    io_req[k]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [8];
    vec_t v;
    int   acks;
    bit   seen;

    // inst, cpu_en, cpu_we, cpu_addr, cpu_wdata, io_en, io_we, io_addr, io_wdata, first_io
    vecs[0] = '{0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0};
    vecs[1] = '{0, 1'b1, 1'b1, 16'h0300, 16'hA5A5, 1'b1, 1'b0, 16'h0041, 16'h0000, 1'b0};
    vecs[2] = '{0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{0, 1'b1, 1'b0, 16'h0777, 16'h0000, 1'b1, 1'b1, 16'h0042, 16'h1111, 1'b1};
    vecs[4] = '{1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'h00FF, 1'b0};
    vecs[5] = '{1, 1'b1, 1'b0, 16'h2222, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{1, 1'b1, 1'b1, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1};
    vecs[7] = '{1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0;
      cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
      io_req[k]  = 1'b0; io_we[k]  = 1'b0; io_addr[k]  = '0; io_wdata[k]  = '0;
      mrd_cpu[k] = '0;   mrd_io[k] = '0;
    end
    #1;
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    #1;
    chk("reset_outs_0", outs(0), '0);
    chk("reset_outs_1", outs(1), '0);
    repeat (2) @(posedge CLK);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Request dropped one cycle after grant still completes and acks once.
    push_txn(1, '{1'b0, 1'b0, 16'h0ABC, 16'h0000, rd_model(16'h0ABC)});
    mrd_cpu[1] = rd_model(16'h0ABC);
    @(posedge CLK); #1;
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 16'h0ABC;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge CLK); #1;
      seen = (grant[1] == 2'b01);
    end
    chk("drop_grant_seen", 80'(grant[1]), 80'(2'b01));
    @(posedge CLK); #1;
    cpu_req[1] = 1'b0;
    acks = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (cpu_ack[1]) acks++;
    end
    chk("drop_ack_count", 80'(acks), 80'(1));

    // Reset during the strobe phase of a CPU read: nothing acks afterwards.
    push_txn(1, '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF});
    @(posedge CLK); #1;
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 16'h0040;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge CLK); #1;
      seen = mem_re[1];
    end
    chk("rst_strobe_seen", 80'(mem_re[1]), 80'(1));
    #2;
    rst[1] = 1'b1;
    #1;
    chk("rst_async_outs", outs(1), '0);
    cpu_req[1] = 1'b0;
    @(negedge CLK);
    mon[1].q.delete();
    mrd_cpu[1] = '0;
    mrd_io[1]  = '0;
    @(posedge CLK); #1;
    rst[1] = 1'b0;
    acks = 0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (cpu_ack[1] || io_ack[1]) acks++;
    end
    chk("rst_no_ack", 80'(acks), 80'(0));
    chk("rst_idle_after", outs(1), '0);

    v = vecs[7];
    run_vec(v);

    repeat (4) @(posedge CLK);
    #1;
    chk("queue0_drained", 80'(mon[0].q.size()), 80'(0));
    chk("queue1_drained", 80'(mon[1].q.size()), 80'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1: memory strobe cycles per access; legal range 1..15.
REQ-002 SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cpu_req  input  1  CPU access request; held until cpu_ack.
REQ-005 SHALL have port cpu_we  input  1  CPU request type: 1 = write, 0 = read.
REQ-006 SHALL have port cpu_addr  input  16  CPU word address.
REQ-007 SHALL have port cpu_wdata  input  16  CPU write data.
REQ-008 SHALL have port cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-009 SHALL have port cpu_rdata  output  16  CPU read data; valid while cpu_ack=1.
REQ-010 SHALL have ports io_req/io_we/io_addr/io_wdata/io_ack/io_rdata with the same directions, widths and meanings as the CPU set, for the I/O-DMA requester.
REQ-011 SHALL have port mem_addr  output  16  memory address.
REQ-012 SHALL have port mem_wdata  output  16  memory write data.
REQ-013 SHALL have port mem_re  output  1  memory read strobe.
REQ-014 SHALL have port mem_we  output  1  memory write strobe.
REQ-015 SHALL have port mem_rdata  input  16  memory read data, valid in the last strobe cycle.
REQ-016 SHALL have port grant  output  2  current owner: 00 none, 01 CPU, 10 IO.
REQ-017 SHALL have port busy  output  1  high in every non-IDLE state.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-019 IDLE: with any request at a rising edge, SHALL latch winner's addr, wdata and we, set grant, load wait counter with WAIT_STATES-1, go to ACCESS.
REQ-020 Both requests in IDLE SHALL grant the requester not granted last (round-robin); last_owner SHALL reset to IO, so CPU wins the first tie.
REQ-021 ACCESS: mem_re = !we_latched, mem_we = we_latched, mem_addr/mem_wdata from latches; counter decrements each cycle; at zero, mem_rdata SHALL be captured into the owner's rdata register and the FSM SHALL go to DONE.
REQ-022 DONE: SHALL pulse the owner's ack for exactly one cycle, update last_owner, clear grant and return to IDLE.
REQ-023 Latency: request sampled at edge N, strobes in cycles N+1..N+WAIT_STATES, ack in cycle N+WAIT_STATES+1, next grant at edge N+WAIT_STATES+2 at the earliest.
REQ-024 Strobes and acks SHALL be low outside ACCESS and DONE respectively; mem_re and mem_we SHALL never be high together.
REQ-025 A request dropped mid-access SHALL NOT abort it; the access completes and ack still pulses.
REQ-026 Requests arriving during ACCESS or DONE SHALL wait; they are not lost if held.
REQ-027 For writes, rdata registers SHALL hold their previous values.
REQ-028 The non-owner's ack SHALL stay 0 throughout.

Reset
REQ-029 Reset high SHALL immediately force IDLE, grant=00, busy=0, mem_re=mem_we=0, both acks=0, mem_addr/mem_wdata=0, both rdata=0, counter=0, last_owner=IO, regardless of the FSM state at the time.
REQ-030 An access interrupted by reset SHALL NOT be acked after reset releases.

Structure
REQ-031 State encodings (IDLE=0, ACCESS=1, DONE=2) and grant codes (NONE/CPU/IO) SHALL live in the shared processor constants package.
REQ-032 A single flat module is sufficient; no sub-module is required.

Verification
REQ-033 Reset mid-access: Reset pulsed during the ACCESS state of a CPU read -> all outputs 0 asynchronously; no cpu_ack after release.
REQ-034 CPU read, WAIT_STATES=1: cpu_req with cpu_addr=0x0040, mem_rdata=0xBEEF -> mem_re is high for 1 cycle with mem_addr=0x0040; next cycle cpu_ack=1 and cpu_rdata=0xBEEF.
REQ-035 IO write, WAIT_STATES=3: io_req, io_we=1, io_addr=0x1234, io_wdata=0x00FF -> mem_we is high for 3 cycles with those values; io_ack=1 on the 4th cycle; io_rdata unchanged.
REQ-036 Tie after reset: both requests held -> CPU served first, then IO, then CPU; acks alternate and grant is never 11.
REQ-037 Request dropped: cpu_req deasserted one cycle after grant -> access completes and cpu_ack still pulses once.
